// File: rtl/secuenciador_iir.sv
// Control sequencer for a shared-multiplier direct-form-II biquad datapath.
// Walks a fixed 7-state schedule per ADC sample, with a one-deep sample queue.
module secuenciador_iir #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Bandera_ADC,
    input  logic             Borrar_Desborde,
    output logic [2:0]       SelectorConst,
    output logic [1:0]       SelectorFk,
    output logic             sel_acum,
    output logic             Acum_En,
    output logic             Acum_Clr,
    output logic             Shift_En,
    output logic             Yk_En,
    output logic             Bandera_Listo,
    output logic             Ocupado,
    output logic             Desborde,
    output logic [CNT_W-1:0] Conteo
);

    typedef enum logic [2:0] {
        StIdle, StF1, StF2, StSh, StY0, StY1, StY2, StDone
    } state_e;

    state_e           state_q, state_d;
    logic             adc_prev_q;
    logic             pend_q, pend_d;
    logic             desb_q, desb_d;
    logic [CNT_W-1:0] conteo_q, conteo_d;
    logic             adc_edge;

    assign adc_edge = Bandera_ADC & ~adc_prev_q;

    // adc_prev_q resets high so a level held across reset release is not an edge
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= StIdle;
            adc_prev_q <= 1'b1;
            pend_q     <= 1'b0;
            desb_q     <= 1'b0;
            conteo_q   <= '0;
        end else begin
            state_q    <= state_d;
            adc_prev_q <= Bandera_ADC;
            pend_q     <= pend_d;
            desb_q     <= desb_d;
            conteo_q   <= conteo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        desb_d   = desb_q;
        conteo_d = conteo_q;

        if (Borrar_Desborde) desb_d = 1'b0;
        // Set overrides the clear when both land in the same cycle
        if (adc_edge && (state_q != StIdle)) begin
            if (pend_q) desb_d = 1'b1;
            else        pend_d = 1'b1;
        end

        case (state_q)
            StIdle: if (adc_edge) state_d = StF1;
            StF1:   state_d = StF2;
            StF2:   state_d = StSh;
            StSh:   state_d = StY0;
            StY0:   state_d = StY1;
            StY1:   state_d = StY2;
            StY2:   state_d = StDone;
            StDone: begin
                conteo_d = conteo_q + CNT_W'(1);
                // An edge during DONE is consumed directly by the restart
                pend_d   = 1'b0;
                state_d  = (pend_q || adc_edge) ? StF1 : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        SelectorConst = 3'd7;
        SelectorFk    = 2'd3;
        sel_acum      = 1'b0;
        Acum_En       = 1'b0;
        Acum_Clr      = 1'b0;
        Shift_En      = 1'b0;
        Yk_En         = 1'b0;
        Bandera_Listo = 1'b0;
        Ocupado       = (state_q != StIdle);

        case (state_q)
            StF1: begin
                sel_acum      = 1'b1;
                SelectorConst = 3'd0;
                SelectorFk    = 2'd1;
                Acum_En       = 1'b1;
            end
            StF2: begin
                SelectorConst = 3'd1;
                SelectorFk    = 2'd2;
                Acum_En       = 1'b1;
            end
            StSh: begin
                Shift_En = 1'b1;
                Acum_Clr = 1'b1;
            end
            StY0: begin
                SelectorConst = 3'd2;
                SelectorFk    = 2'd0;
                Acum_En       = 1'b1;
            end
            StY1: begin
                SelectorConst = 3'd3;
                SelectorFk    = 2'd1;
                Acum_En       = 1'b1;
            end
            StY2: begin
                SelectorConst = 3'd4;
                SelectorFk    = 2'd2;
                Acum_En       = 1'b1;
            end
            StDone: begin
                Yk_En         = 1'b1;
                Bandera_Listo = 1'b1;
            end
            default: ;
        endcase
    end

    assign Desborde = desb_q;
    assign Conteo   = conteo_q;

endmodule

// File: tb/tb_secuenciador_iir.sv
// Directed bench for secuenciador_iir with a small behavioural datapath model.
// A second instance with a 2-bit counter exercises counter wrap-around.
module tb_secuenciador_iir;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Bandera_ADC = 1'b0;
    logic        Borrar_Desborde = 1'b0;
    logic [2:0]  SelectorConst;
    logic [1:0]  SelectorFk;
    logic        sel_acum, Acum_En, Acum_Clr, Shift_En, Yk_En;
    logic        Bandera_Listo, Ocupado, Desborde;
    logic [15:0] Conteo;

    logic [2:0]  s_SelectorConst;
    logic [1:0]  s_SelectorFk;
    logic        s_sel_acum, s_Acum_En, s_Acum_Clr, s_Shift_En, s_Yk_En;
    logic        s_Bandera_Listo, s_Ocupado, s_Desborde;
    logic [1:0]  s_Conteo;

    int n_assert = 0;
    int n_fail   = 0;

    // {const(3), fk(2), sel_acum, acum_en, acum_clr, shift_en, yk_en, listo, ocupado}
    localparam logic [12:0] SCHED [8] = '{
        13'b111_11_0000000,  // IDLE
        13'b000_01_1100001,  // F1
        13'b001_10_0100001,  // F2
        13'b111_11_0011001,  // SH
        13'b010_00_0100001,  // Y0
        13'b011_01_0100001,  // Y1
        13'b100_10_0100001,  // Y2
        13'b111_11_0000111   // DONE
    };

    logic [12:0] ov;
    assign ov = {SelectorConst, SelectorFk, sel_acum, Acum_En, Acum_Clr, Shift_En,
                 Yk_En, Bandera_Listo, Ocupado};

    secuenciador_iir dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .Bandera_ADC     (Bandera_ADC),
        .Borrar_Desborde (Borrar_Desborde),
        .SelectorConst   (SelectorConst),
        .SelectorFk      (SelectorFk),
        .sel_acum        (sel_acum),
        .Acum_En         (Acum_En),
        .Acum_Clr        (Acum_Clr),
        .Shift_En        (Shift_En),
        .Yk_En           (Yk_En),
        .Bandera_Listo   (Bandera_Listo),
        .Ocupado         (Ocupado),
        .Desborde        (Desborde),
        .Conteo          (Conteo)
    );

    secuenciador_iir #(.CNT_W(2)) dut_small (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .Bandera_ADC     (Bandera_ADC),
        .Borrar_Desborde (Borrar_Desborde),
        .SelectorConst   (s_SelectorConst),
        .SelectorFk      (s_SelectorFk),
        .sel_acum        (s_sel_acum),
        .Acum_En         (s_Acum_En),
        .Acum_Clr        (s_Acum_Clr),
        .Shift_En        (s_Shift_En),
        .Yk_En           (s_Yk_En),
        .Bandera_Listo   (s_Bandera_Listo),
        .Ocupado         (s_Ocupado),
        .Desborde        (s_Desborde),
        .Conteo          (s_Conteo)
    );

    always #5 Clk = ~Clk;

    // Datapath model: a1 = a2 = 0, b0 = 1, b1 = b2 = 0, Uk = 1000
    int uk = 1000;
    int acc = 0, f0 = 0, f1 = 0, f2 = 0, yk = 0;
    int cst, fv, sum;

    always_comb begin
        cst = 0;
        fv  = 0;
        case (SelectorConst)
            3'd2:    cst = 1;
            default: cst = 0;
        endcase
        case (SelectorFk)
            2'd0:    fv = f0;
            2'd1:    fv = f1;
            2'd2:    fv = f2;
            default: fv = 0;
        endcase
        sum = (sel_acum ? uk : acc) + cst * fv;
    end

    always_ff @(posedge Clk) begin
        if (Acum_Clr)     acc <= 0;
        else if (Acum_En) acc <= sum;
        if (Shift_En) begin
            f2 <= f1;
            f1 <= f0;
            f0 <= acc;
        end
        if (Yk_En) yk <= acc;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Edges at E, E+2, E+4; optionally hold Borrar_Desborde from E+4 through E+5
    task automatic burst(input bit with_clear, input int exp_cnt);
        int n_listo;
        n_listo = 0;
        Bandera_ADC = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (Bandera_Listo) n_listo++;
            if (i == 5) chk("overrun_set", 32'(Desborde), 32'd1);
            if (with_clear && i == 6) chk("overrun_clear", 32'(Desborde), 32'd0);
            if (!with_clear && i == 4) chk("no_overrun_yet", 32'(Desborde), 32'd0);
            case (i)
                1, 3, 5: Bandera_ADC = 1'b0;
                2, 4:    Bandera_ADC = 1'b1;
                default: ;
            endcase
            if (with_clear && i == 4) Borrar_Desborde = 1'b1;
            if (with_clear && i == 6) Borrar_Desborde = 1'b0;
        end
        chk("overrun_listo_cnt", 32'(n_listo), 32'd2);
        chk("overrun_conteo", 32'(Conteo), 32'(exp_cnt));
    endtask

    initial begin
        int n_listo, l1, l2;

        // Reset with the ADC level held high
        Bandera_ADC = 1'b1;
        #12;
        chk("reset_outputs", 32'(ov), 32'(SCHED[0]));
        chk("reset_conteo", 32'(Conteo), 32'd0);
        chk("reset_desborde", 32'(Desborde), 32'd0);
        Reset_n = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            chk("held_level_idle", 32'(ov), 32'(SCHED[0]));
            if (c == 5) Bandera_ADC = 1'b0;
        end
        tick();
        Bandera_ADC = 1'b1;  // cycle 10
        for (int s = 1; s <= 7; s++) begin
            tick();
            chk("schedule", 32'(ov), 32'(SCHED[s]));
        end
        tick();
        chk("after_done_idle", 32'(ov), 32'(SCHED[0]));
        chk("first_conteo", 32'(Conteo), 32'd1);
        chk("yk_value", 32'(yk), 32'd1000);
        Bandera_ADC = 1'b0;

        // Edges at E and E+4: queued, no overrun
        tick();
        tick();
        Bandera_ADC = 1'b1;
        n_listo = 0;
        l1 = 0;
        l2 = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (Bandera_Listo) begin
                n_listo++;
                if (n_listo == 1) l1 = i;
                else l2 = i;
            end
            if (i == 8) chk("queued_f1", 32'(ov), 32'(SCHED[1]));
            if (i == 2 || i == 5) Bandera_ADC = 1'b0;
            if (i == 4) Bandera_ADC = 1'b1;
        end
        chk("queued_listo_cnt", 32'(n_listo), 32'd2);
        chk("queued_listo1", 32'(l1), 32'd7);
        chk("queued_listo2", 32'(l2), 32'd14);
        chk("queued_desborde", 32'(Desborde), 32'd0);
        chk("queued_conteo", 32'(Conteo), 32'd3);

        // Overrun, then overrun coinciding with a clear
        tick();
        burst(1'b0, 5);
        chk("desborde_sticky", 32'(Desborde), 32'd1);
        tick();
        burst(1'b1, 7);

        // Reset asserted during Y1
        tick();
        Bandera_ADC = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 1) Bandera_ADC = 1'b0;
        end
        chk("in_y1", 32'(ov), 32'(SCHED[5]));
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(ov), 32'(SCHED[0]));
        chk("async_reset_conteo", 32'(Conteo), 32'd0);
        Reset_n = 1'b1;
        tick();
        tick();
        Bandera_ADC = 1'b1;
        for (int s = 1; s <= 7; s++) begin
            tick();
            chk("post_reset_sched", 32'(ov), 32'(SCHED[s]));
            if (s == 1) Bandera_ADC = 1'b0;
        end
        tick();
        chk("post_reset_conteo", 32'(Conteo), 32'd1);

        // Edge during DONE restarts with no idle gap
        tick();
        Bandera_ADC = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 1) Bandera_ADC = 1'b0;
            if (i == 7) Bandera_ADC = 1'b1;
            if (i == 8) begin
                chk("done_edge_f1", 32'(ov), 32'(SCHED[1]));
                Bandera_ADC = 1'b0;
            end
        end
        chk("done_edge_listo", 32'(Bandera_Listo), 32'd1);
        tick();
        chk("done_edge_conteo", 32'(Conteo), 32'd3);
        chk("small_conteo_3", 32'(s_Conteo), 32'd3);

        // One more iteration wraps the 2-bit counter
        tick();
        Bandera_ADC = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) Bandera_ADC = 1'b0;
        end
        chk("conteo_4", 32'(Conteo), 32'd4);
        chk("small_conteo_wrap", 32'(s_Conteo), 32'd0);
        chk("yk_final", 32'(yk), 32'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/secuenciador_iir.md
# secuenciador_iir

Control sequencer for the second-order direct-form-II IIR low-pass datapath, which has one shared multiplier/adder, an accumulator and an f[k] shift register. For each accepted ADC sample it steps the constant mux, f-history mux, adder-input mux and register enables through a fixed 7-state schedule. It queues one sample that arrives while busy and flags overruns. It also counts completed outputs and pulses `Bandera_Listo` when Yk is valid.

## Interface
- `CNT_W`, 16, width of completed-sample counter
- `Clk`  in  1  single system clock; all state changes on rising edge
- `Reset_n`  in  1  asynchronous, active-low reset
- `Bandera_ADC`  in  1  ADC sample-valid level; a rising edge requests one filter iteration
- `Borrar_Desborde`  in  1  synchronous clear of `Desborde`
- `SelectorConst`  out  3  constant select: 0=-a1, 1=-a2, 2=b0, 3=b1, 4=b2, 7=idle
- `SelectorFk`  out  2  multiplicand select: 0=f[k], 1=f[k-1], 2=f[k-2], 3=idle
- `sel_acum`  out  1  adder input: 1=Uk, 0=accumulator
- `Acum_En`  out  1  accumulator load enable
- `Acum_Clr`  out  1  synchronous accumulator clear
- `Shift_En`  out  1  f-history shift: f[k-2]<=f[k-1], f[k-1]<=f[k], f[k]<=acc
- `Yk_En`  out  1  output register load
- `Bandera_Listo`  out  1  one-cycle pulse, Yk valid
- `Ocupado`  out  1  iteration in progress
- `Desborde`  out  1  sticky overrun flag
- `Conteo`  out  CNT_W  completed iterations, modulo 2^CNT_W

## Operation
- Edge detector: the previous-`Bandera_ADC` register resets to 1. A level held high across reset release does not trigger.
- FSM states and outputs. Any output not listed is 0. Selectors hold their idle values except where given.
  - IDLE: on an edge, go to F1.
  - F1: sel_acum=1, SelectorConst=0, SelectorFk=1, Acum_En=1. Accumulator loads Uk - a1·f[k-1]. Go to F2.
  - F2: sel_acum=0, SelectorConst=1, SelectorFk=2, Acum_En=1. Accumulator adds -a2·f[k-2]. Go to SH.
  - SH: Shift_En=1, Acum_Clr=1. Go to Y0.
  - Y0: sel_acum=0, SelectorConst=2, SelectorFk=0, Acum_En=1. Go to Y1.
  - Y1: sel_acum=0, SelectorConst=3, SelectorFk=1, Acum_En=1. Go to Y2.
  - Y2: sel_acum=0, SelectorConst=4, SelectorFk=2, Acum_En=1. Go to DONE.
  - DONE: Yk_En=1, Bandera_Listo=1, Conteo increments. Go to F1 if `Pendiente` is set, else IDLE.
- `Ocupado` = 1 in all states except IDLE.
- Pending queue (internal `Pendiente`, depth 1):
  - An edge in any non-IDLE state, including DONE, sets `Pendiente`.
  - The transition DONE→F1 clears it.
  - An edge while `Pendiente` is already set sets `Desborde`; the sample is dropped.
- `Desborde` priority: if set and `Borrar_Desborde` occur in the same cycle, set wins.
- `Conteo` wraps from 2^CNT_W-1 to 0 with no flag.
- Arithmetic, truncation and the constant store are in the datapath. Constants are stored pre-negated for a1 and a2. This block has no data path.
- Illegal state encodings go to IDLE on the next clock.

## Timing
- Reset (asynchronous, immediate):
  - State returns to IDLE.
  - All enables, `Bandera_Listo`, `Ocupado`, `Desborde`, `Pendiente` and `Conteo` go to 0.
  - SelectorConst=7, SelectorFk=3, sel_acum=0.
- Reset mid-iteration abandons the iteration. Datapath registers are not cleared by this block.
- Cycle E = first edge where `Bandera_ADC`=1 and the previous value was 0.
  - F1 is in cycle E+1, DONE in cycle E+7.
  - `Bandera_Listo` is high for exactly cycle E+7.
  - Yk is valid from E+8.
- Minimum edge spacing without queuing: 8 cycles. An edge at E+7 is queued.
- Back-to-back queued iteration: DONE at cycle D, F1 at D+1. No IDLE cycle in between.
- Outputs are registered or decoded from state only. `Bandera_ADC` has no combinational path to any output.

## Test plan
- Reset release with `Bandera_ADC`=1 held → stays IDLE, no Listo. Drop the level, then raise it at cycle 10 → Listo at cycle 17, `Conteo`=1.
- Single edge → check every selector and enable against the F1..DONE schedule, cycle by cycle. With a1=a2=0, b0=1, b1=b2=0 and Uk=1000 → Yk=1000.
- Edges at E and E+4 → second iteration starts at E+8, two Listo pulses 7 cycles apart, `Desborde`=0.
- Edges at E, E+2 and E+4 → `Desborde`=1 at E+5, only two Listo pulses. Assert `Borrar_Desborde` together with another overrun edge → `Desborde` stays 1.
- Assert `Reset_n`=0 in Y1 → outputs return to idle values within the same cycle. The next edge runs a full 7-cycle iteration.
- Preload `Conteo` to 2^16-1 via 65535 iterations (or force) → the next Listo gives `Conteo`=0.
